// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard control for a 5-stage MIPS. It detects the
//               hazards that operand forwarding cannot cover: load-use,
//               decode-stage branch/jr compares, and HI/LO or MDU accesses
//               while the multi-cycle multiply/divide unit is busy. A single
//               combined stall drives stallF, stallD and flushE. The block
//               also tracks MDU occupancy and counts stall cycles.
//
// Ports       : clk, rst        - clock, synchronous active-high reset
//               rsD, rtD        - Decode source registers
//               write_regE, RegWriteE, MemtoRegE - Execute producer info
//               write_regM, MemtoRegM            - Memory producer info
//               BranchD, JumpRegD                - Decode compare users
//               mdu_opD, mfhiloD                 - Decode MDU/HI-LO users
//               mdu_startE, mdu_is_divE          - MDU launch in Execute
//               stat_clr        - clear the stall statistics counter
//               stallF, stallD, flushE - pipeline control outputs
//               mdu_busy        - MDU result not yet valid
//               stall_count     - saturating count of stallD cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       write_regE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [4:0]       write_regM,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             JumpRegD,
    input  logic             mdu_opD,
    input  logic             mfhiloD,
    input  logic             mdu_startE,
    input  logic             mdu_is_divE,
    input  logic             stat_clr,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    // MDU down-counter sized to hold the longer of the two latencies.
    localparam int               c_MAX_LAT  = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int               c_MCW      = $clog2(c_MAX_LAT + 1);
    localparam logic [c_MCW-1:0] c_MUL_LD   = c_MCW'(MUL_LAT);
    localparam logic [c_MCW-1:0] c_DIV_LD   = c_MCW'(DIV_LAT);
    localparam logic [c_MCW-1:0] c_MCNT_ONE = c_MCW'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [c_MCW-1:0] r_mdu_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_mdu_idle;
    logic w_e_nonzero;
    logic w_m_nonzero;
    logic w_e_hits_dsrc;
    logic w_m_hits_dsrc;
    logic w_lwstall;
    logic w_brstall;
    logic w_mdustall;
    logic w_stall;

    assign w_mdu_idle  = (r_mdu_cnt == '0);
    assign w_e_nonzero = (write_regE != 5'd0);
    assign w_m_nonzero = (write_regM != 5'd0);

    // Load-use: the loaded value is not available until after Memory.
    assign w_lwstall = MemtoRegE & w_e_nonzero &
                       ((rsD == write_regE) | (rtD == write_regE));

    // Decode compare sources: rs always, rt only for beq/bne (jr ignores rt).
    assign w_e_hits_dsrc = (write_regE == rsD) | (BranchD & (write_regE == rtD));
    assign w_m_hits_dsrc = (write_regM == rsD) | (BranchD & (write_regM == rtD));

    // An ALU result already in Memory is forwarded into Decode, so only a
    // load in Memory stalls the compare; any register writer in Execute does.
    assign w_brstall = (BranchD | JumpRegD) &
                       ((RegWriteE & w_e_nonzero & w_e_hits_dsrc) |
                        (MemtoRegM & w_m_nonzero & w_m_hits_dsrc));

    // A start in Execute this cycle counts as busy so the follower cannot
    // slip in before the counter has loaded.
    assign w_mdustall = (mdu_opD | mfhiloD) & (~w_mdu_idle | mdu_startE);

    assign w_stall = ~rst & (w_lwstall | w_brstall | w_mdustall);

    assign stallF = w_stall;
    assign stallD = w_stall;
    assign flushE = w_stall;

    // MDU occupancy: starts while busy are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdu_cnt <= '0;
        end else if (mdu_startE && w_mdu_idle) begin
            r_mdu_cnt <= mdu_is_divE ? c_DIV_LD : c_MUL_LD;
        end else if (!w_mdu_idle) begin
            r_mdu_cnt <= r_mdu_cnt - c_MCNT_ONE;
        end
    end

    assign mdu_busy = ~w_mdu_idle;

    // Stall statistics: clear wins over increment; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (stat_clr) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. Two instances share the
//               stimulus: one with default parameters and one with a 4-bit
//               stall counter to reach saturation quickly. Expected values
//               come from directed constants and a cycle-stamped model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk;
    logic       rst;
    logic [4:0] rsD, rtD, write_regE, write_regM;
    logic       RegWriteE, MemtoRegE, MemtoRegM;
    logic       BranchD, JumpRegD, mdu_opD, mfhiloD;
    logic       mdu_startE, mdu_is_divE, stat_clr;

    logic        stallF, stallD, flushE, mdu_busy;
    logic [31:0] stall_count;
    logic        stallF4, stallD4, flushE4, mdu_busy4;
    logic [3:0]  stall_count4;

    int checks   = 0;
    int failures = 0;

    // Model state: cycle stamp, cycle at which the MDU becomes free,
    // and the two expected statistics counts.
    longint mdl_cyc     = 0;
    longint mdl_free_at = 0;
    longint mdl_cnt     = 0;
    longint mdl_cnt4    = 0;

    hazard_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD),
        .write_regE(write_regE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .write_regM(write_regM), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JumpRegD(JumpRegD), .mdu_opD(mdu_opD), .mfhiloD(mfhiloD),
        .mdu_startE(mdu_startE), .mdu_is_divE(mdu_is_divE), .stat_clr(stat_clr),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    hazard_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD),
        .write_regE(write_regE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .write_regM(write_regM), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JumpRegD(JumpRegD), .mdu_opD(mdu_opD), .mfhiloD(mfhiloD),
        .mdu_startE(mdu_startE), .mdu_is_divE(mdu_is_divE), .stat_clr(stat_clr),
        .stallF(stallF4), .stallD(stallD4), .flushE(flushE4),
        .mdu_busy(mdu_busy4), .stall_count(stall_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit mdl_busy();
        return mdl_cyc < mdl_free_at;
    endfunction

    function automatic bit uses_src(input logic [4:0] r);
        return (r == rsD) || (BranchD && (r == rtD));
    endfunction

    function automatic bit mdl_stall();
        bit lw, br, md;
        if (rst) return 1'b0;
        lw = MemtoRegE && (write_regE != 0) && ((rsD == write_regE) || (rtD == write_regE));
        br = (BranchD || JumpRegD) &&
             ((RegWriteE && (write_regE != 0) && uses_src(write_regE)) ||
              (MemtoRegM && (write_regM != 0) && uses_src(write_regM)));
        md = (mdu_opD || mfhiloD) && (mdl_busy() || mdu_startE);
        return lw || br || md;
    endfunction

    // Advance model and DUT by one clock; inputs are held across the edge.
    task automatic tick();
        bit s;
        s = mdl_stall();
        if (rst) begin
            mdl_free_at = 0;
            mdl_cnt     = 0;
            mdl_cnt4    = 0;
        end else begin
            if (mdu_startE && !mdl_busy())
                mdl_free_at = mdl_cyc + (mdu_is_divE ? DIV_LAT : MUL_LAT) + 1;
            if (stat_clr) begin
                mdl_cnt  = 0;
                mdl_cnt4 = 0;
            end else if (s) begin
                if (mdl_cnt  < 64'hFFFF_FFFF) mdl_cnt  = mdl_cnt + 1;
                if (mdl_cnt4 < 15)            mdl_cnt4 = mdl_cnt4 + 1;
            end
        end
        mdl_cyc = mdl_cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsD = 0; rtD = 0; write_regE = 0; write_regM = 0;
        RegWriteE = 0; MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; JumpRegD = 0; mdu_opD = 0; mfhiloD = 0;
        mdu_startE = 0; mdu_is_divE = 0; stat_clr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        // Hazard inputs present while reset is held: stalls must stay low.
        MemtoRegE = 1; write_regE = 8; rsD = 8; mfhiloD = 1; mdu_startE = 1;
        #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b000) begin
            failures++;
            $display("FAIL reset_stall_forced actual=%b expected=000", {stallF, stallD, flushE});
        end
        tick();
        checks++;
        if (mdu_busy !== 1'b0 || stall_count !== 32'd0 || stall_count4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b cnt=%0d cnt4=%0d expected 0/0/0",
                     mdu_busy, stall_count, stall_count4);
        end
        idle_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        MemtoRegE = 1; write_regE = 8; rsD = 8;
        #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            failures++;
            $display("FAIL load_use_rs actual=%b expected=111", {stallF, stallD, flushE});
        end
        tick();
        rsD = 0; rtD = 8;
        #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            failures++;
            $display("FAIL load_use_rt actual=%b expected=111", {stallF, stallD, flushE});
        end
        tick();
        write_regE = 0; rsD = 0; rtD = 0;
        #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b000) begin
            failures++;
            $display("FAIL load_use_r0 actual=%b expected=000", {stallF, stallD, flushE});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch();
        idle_inputs();
        BranchD = 1; rtD = 9; rsD = 3; RegWriteE = 1; write_regE = 9;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            failures++;
            $display("FAIL branch_alu_E_rt actual=%b expected=1", stallD);
        end
        tick();
        BranchD = 0; JumpRegD = 1;
        #1;
        checks++;
        if (stallD !== 1'b0) begin
            failures++;
            $display("FAIL jr_ignores_rt actual=%b expected=0", stallD);
        end
        tick();
        idle_inputs();
        BranchD = 1; rsD = 5; MemtoRegM = 1; write_regM = 5;
        #1;
        checks++;
        if (stallD !== 1'b1) begin
            failures++;
            $display("FAIL branch_load_M actual=%b expected=1", stallD);
        end
        tick();
        MemtoRegM = 0;
        #1;
        checks++;
        if (stallD !== 1'b0) begin
            failures++;
            $display("FAIL branch_alu_M_forwarded actual=%b expected=0", stallD);
        end
        tick();
        idle_inputs();
        JumpRegD = 1; rsD = 0; RegWriteE = 1; write_regE = 0;
        #1;
        checks++;
        if (stallD !== 1'b0) begin
            failures++;
            $display("FAIL jr_r0 actual=%b expected=0", stallD);
        end
        tick();
        idle_inputs();
    endtask

    task automatic run_mdu(input bit is_div, input int lat);
        idle_inputs();
        mfhiloD = 1;
        for (int k = 0; k <= lat + 1; k++) begin
            mdu_startE  = (k == 0);
            mdu_is_divE = is_div;
            #1;
            checks++;
            if (mdu_busy !== ((k >= 1) && (k <= lat))) begin
                failures++;
                $display("FAIL mdu_busy div=%0d cyc=%0d actual=%b expected=%b",
                         is_div, k, mdu_busy, ((k >= 1) && (k <= lat)));
            end
            checks++;
            if (stallD !== (k <= lat)) begin
                failures++;
                $display("FAIL mdu_stall div=%0d cyc=%0d actual=%b expected=%b",
                         is_div, k, stallD, (k <= lat));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mdu_latency();
        run_mdu(1'b0, MUL_LAT);
        run_mdu(1'b1, DIV_LAT);
    endtask

    task automatic test_reset_mid_div();
        idle_inputs();
        mdu_startE = 1; mdu_is_divE = 1;
        tick();
        mdu_startE = 0; mfhiloD = 1;
        for (int k = 1; k < 10; k++) tick();
        rst = 1;
        #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b000 || mdu_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_div_c10 stalls=%b busy=%b expected 000/1",
                     {stallF, stallD, flushE}, mdu_busy);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (mdu_busy !== 1'b0 || stall_count !== 32'd0 || stall_count4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_div_c11 busy=%b cnt=%0d cnt4=%0d expected 0/0/0",
                     mdu_busy, stall_count, stall_count4);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_count();
        idle_inputs();
        stat_clr = 1;
        tick();
        stat_clr = 0;
        MemtoRegE = 1; write_regE = 7; rsD = 7;
        for (int k = 0; k < 3; k++) tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_count !== 32'd3 || stall_count4 !== 4'd3) begin
            failures++;
            $display("FAIL stall_count_3 actual=%0d/%0d expected=3/3", stall_count, stall_count4);
        end
        MemtoRegE = 1; write_regE = 7; rsD = 7; stat_clr = 1;
        tick();
        stat_clr = 0;
        checks++;
        if (stall_count !== 32'd0 || stall_count4 !== 4'd0) begin
            failures++;
            $display("FAIL stat_clr_priority actual=%0d/%0d expected=0/0", stall_count, stall_count4);
        end
        // Counter just cleared, stall still asserted: 20 more stalls.
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (stall_count !== 32'd20 || stall_count4 !== 4'd15) begin
            failures++;
            $display("FAIL stall_count_saturate actual=%0d/%0d expected=20/15",
                     stall_count, stall_count4);
        end
        tick(); tick();
        checks++;
        if (stall_count4 !== 4'd15) begin
            failures++;
            $display("FAIL stall_count_hold actual=%0d expected=15", stall_count4);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit exp_s;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            rsD         = 5'($urandom_range(0, 3));
            rtD         = 5'($urandom_range(0, 3));
            write_regE  = 5'($urandom_range(0, 3));
            write_regM  = 5'($urandom_range(0, 3));
            RegWriteE   = 1'($urandom_range(0, 1));
            MemtoRegE   = ($urandom_range(0, 3) == 0);
            MemtoRegM   = ($urandom_range(0, 3) == 0);
            BranchD     = ($urandom_range(0, 3) == 0);
            JumpRegD    = ($urandom_range(0, 5) == 0);
            mdu_opD     = ($urandom_range(0, 7) == 0);
            mfhiloD     = ($urandom_range(0, 7) == 0);
            mdu_startE  = ($urandom_range(0, 9) == 0);
            mdu_is_divE = ($urandom_range(0, 3) == 0);
            stat_clr    = ($urandom_range(0, 99) == 0);
            #1;
            exp_s = mdl_stall();
            checks++;
            if ({stallF, stallD, flushE} !== {3{exp_s}}) begin
                failures++;
                $display("FAIL rand_stall i=%0d actual=%b expected=%b",
                         i, {stallF, stallD, flushE}, {3{exp_s}});
            end
            checks++;
            if (mdu_busy !== mdl_busy() || mdu_busy4 !== mdl_busy()) begin
                failures++;
                $display("FAIL rand_busy i=%0d actual=%b/%b expected=%b",
                         i, mdu_busy, mdu_busy4, mdl_busy());
            end
            checks++;
            if (stall_count !== mdl_cnt[31:0] || stall_count4 !== mdl_cnt4[3:0]) begin
                failures++;
                $display("FAIL rand_count i=%0d actual=%0d/%0d expected=%0d/%0d",
                         i, stall_count, stall_count4, mdl_cnt, mdl_cnt4);
            end
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mdu_latency();
        test_reset_mid_div();
        test_stall_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
